// File: rtl/i2c_init_pkg.sv
// i2c_init_pkg: shared types and the AK4619 power-up table for the i2c_init master.
//   entry_t    : one table entry, data byte plus last-of-transaction flag
//   INIT_TABLE : 20 entries, transaction A (config burst) then B (power-up)
//   state_t    : FSM states
//   QUARTERS   : clk quarters per bus symbol
package i2c_init_pkg;
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } entry_t;
  typedef enum logic [2:0] {WAIT, START, BITS, ACK, STOP, GAP, DONE} state_t;
  localparam int QUARTERS = 4;
  localparam int INIT_LEN = 20;
  localparam int IW = $clog2(INIT_LEN);
  localparam entry_t INIT_TABLE [INIT_LEN] = '{
    '{8'h20, 1'b0}, '{8'h01, 1'b0}, '{8'hAE, 1'b0}, '{8'h1C, 1'b0},
    '{8'h00, 1'b0}, '{8'h22, 1'b0}, '{8'h22, 1'b0}, '{8'h30, 1'b0},
    '{8'h30, 1'b0}, '{8'h30, 1'b0}, '{8'h30, 1'b0}, '{8'h22, 1'b0},
    '{8'h00, 1'b0}, '{8'h18, 1'b0}, '{8'h18, 1'b0}, '{8'h18, 1'b0},
    '{8'h18, 1'b1},
    '{8'h20, 1'b0}, '{8'h00, 1'b0}, '{8'h37, 1'b1}
  };
endpackage

// File: rtl/i2c_init_if.sv
// i2c_init_if: open-drain bus intents and completion flag of the init master.
//   scl, sda_out : 1 = release, 0 = pull low
//   done         : sticky high once the whole table has been sent
interface i2c_init_if;
  logic scl;
  logic sda_out;
  logic done;
  modport master (output scl, sda_out, done);
  modport slave (input scl, sda_out, done);
endinterface

// File: rtl/i2c_init.sv
// i2c_init: write-only I2C master sending the codec power-up table once after reset.
//   clk   : bus-timing clock (lrck), rising edge
//   rst_n : asynchronous active-low reset
//   bus   : i2c_init_if master (scl, sda_out, done), all registered
module i2c_init
  import i2c_init_pkg::*;
#(
  parameter int STARTUP_CYCLES = 512,
  parameter int GAP_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  i2c_init_if.master bus
);
  localparam int CW = $clog2(STARTUP_CYCLES + GAP_CYCLES + 1);
  localparam int QW = $clog2(QUARTERS);
  state_t state;
  logic [QW-1:0] q;
  logic [2:0] bitn;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  entry_t cur;
  logic q_last;
  logic scl_pulse;
  assign cur = INIT_TABLE[idx];
  assign q_last = q == QW'(QUARTERS - 1);
  // data/ack clock is high in the middle two quarters only
  assign scl_pulse = q == QW'(1) || q == QW'(2);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      q <= '0;
      bitn <= '0;
      idx <= '0;
      cnt <= '0;
      bus.scl <= 1'b1;
      bus.sda_out <= 1'b1;
      bus.done <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          bus.scl <= 1'b1;
          bus.sda_out <= 1'b1;
          cnt <= cnt == CW'(STARTUP_CYCLES - 1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(STARTUP_CYCLES - 1)) state <= START;
        end
        START: begin
          bus.scl <= q < QW'(2);
          bus.sda_out <= q == QW'(0);
          q <= q + 1'b1;
          bitn <= '0;
          if (q_last) state <= BITS;
        end
        BITS: begin
          bus.scl <= scl_pulse;
          bus.sda_out <= cur.data[3'd7 - bitn];
          q <= q + 1'b1;
          if (q_last) bitn <= bitn + 1'b1;
          if (q_last && bitn == 3'd7) state <= ACK;
        end
        ACK: begin
          bus.scl <= scl_pulse;
          bus.sda_out <= 1'b1;
          q <= q + 1'b1;
          if (q_last && !cur.last) idx <= idx + 1'b1;
          if (q_last) state <= cur.last ? STOP : BITS;
        end
        STOP: begin
          bus.scl <= q != QW'(0);
          bus.sda_out <= q >= QW'(2);
          q <= q + 1'b1;
          cnt <= '0;
          if (q_last && idx != IW'(INIT_LEN - 1)) idx <= idx + 1'b1;
          if (q_last) state <= idx == IW'(INIT_LEN - 1) ? DONE : GAP;
        end
        GAP: begin
          bus.scl <= 1'b1;
          bus.sda_out <= 1'b1;
          cnt <= cnt == CW'(GAP_CYCLES - 1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(GAP_CYCLES - 1)) state <= START;
        end
        DONE: begin
          bus.scl <= 1'b1;
          bus.sda_out <= 1'b1;
          bus.done <= 1'b1;
        end
        default: state <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_init.sv
// tb_i2c_init: bus-decoding bench for i2c_init with randomized reset timing.
module tb_i2c_init;
  localparam int STARTUP = 512;
  localparam int GAPC = 4;
  localparam int Q = 4;
  localparam logic [7:0] TXN_A [17] = '{8'h20, 8'h01, 8'hAE, 8'h1C, 8'h00, 8'h22, 8'h22, 8'h30,
                                        8'h30, 8'h30, 8'h30, 8'h22, 8'h00, 8'h18, 8'h18, 8'h18, 8'h18};
  localparam logic [7:0] TXN_B [3] = '{8'h20, 8'h00, 8'h37};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  i2c_init_if b ();
  i2c_init dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int rel_cyc = 0;
  logic [7:0] exp_bytes [$];
  int txn_len [2] = '{17, 3};
  logic [7:0] got [$];
  int start_t [$];
  int stop_t [$];
  int edges, early_viol, ack_err, proto_err, done_t, done_drop, nbits, t;
  logic active;
  logic [7:0] sh;
  logic pscl = 1'b1, psda = 1'b1, pdone = 1'b0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    t = cyc - rel_cyc;
    if (!rst_n) begin
      got.delete(); start_t.delete(); stop_t.delete();
      active = 0; nbits = 0; edges = 0; early_viol = 0; ack_err = 0;
      proto_err = 0; done_t = -1; done_drop = 0;
    end else begin
      if (t <= STARTUP + 1 && (b.scl !== 1'b1 || b.sda_out !== 1'b1 || b.done !== 1'b0)) early_viol++;
      if (pscl && b.scl && psda && !b.sda_out) begin
        if (active) proto_err++;
        active = 1; nbits = 0; start_t.push_back(t);
      end else if (pscl && b.scl && !psda && b.sda_out) begin
        if (!active || nbits != 1) proto_err++;
        active = 0; nbits = 0; stop_t.push_back(t);
      end else if (b.scl && psda !== b.sda_out) proto_err++;
      if (!pscl && b.scl) begin
        edges++;
        if (!active) proto_err++;
        if (nbits < 8) sh = {sh[6:0], b.sda_out};
        else begin
          if (!b.sda_out) ack_err++;
          got.push_back(sh);
        end
        nbits = nbits == 8 ? 0 : nbits + 1;
      end
      if (pscl && !b.scl) edges++;
      if (!b.scl && !active) proto_err++;
      if (!pdone && b.done) done_t = t;
      if (pdone && !b.done) done_drop++;
    end
    pscl = b.scl; psda = b.sda_out; pdone = b.done;
  end
  task automatic release_reset(input int hold);
    repeat (hold) @(negedge clk);
    #1 rst_n = 1'b1;
    rel_cyc = cyc;
  endtask
  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b.scl !== 1'b1) begin fails++; $display("FAIL reset_scl got %b exp 1", b.scl); end
    checks++; if (b.sda_out !== 1'b1) begin fails++; $display("FAIL reset_sda got %b exp 1", b.sda_out); end
    checks++; if (b.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", b.done); end
    release_reset(5);
  endtask
  task automatic test_startup();
    for (int i = 0; i < STARTUP + 100 && start_t.size() == 0; i++) @(negedge clk);
    checks++;
    if (start_t.size() == 0) begin fails++; $display("FAIL first_start got none exp %0d", STARTUP + 2); end
    else if (start_t[0] != STARTUP + 2) begin fails++; $display("FAIL first_start got %0d exp %0d", start_t[0], STARTUP + 2); end
    checks++; if (early_viol != 0) begin fails++; $display("FAIL startup_idle got %0d bad samples exp 0", early_viol); end
  endtask
  task automatic test_bus_decode();
    for (int i = 0; i < 3000 && stop_t.size() < 2; i++) @(negedge clk);
    checks++; if (got.size() != exp_bytes.size()) begin fails++; $display("FAIL byte_count got %0d exp %0d", got.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size(); i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_bytes[i]) begin
        fails++; $display("FAIL byte_%0d got %h exp %h", i, i < got.size() ? got[i] : 8'hxx, exp_bytes[i]);
      end
    end
    checks++; if (start_t.size() != 2) begin fails++; $display("FAIL start_count got %0d exp 2", start_t.size()); end
    checks++; if (stop_t.size() != 2) begin fails++; $display("FAIL stop_count got %0d exp 2", stop_t.size()); end
    checks++; if (ack_err != 0) begin fails++; $display("FAIL ack_released got %0d low acks exp 0", ack_err); end
    checks++; if (proto_err != 0) begin fails++; $display("FAIL protocol got %0d violations exp 0", proto_err); end
  endtask
  task automatic test_timing();
    checks++;
    if (start_t.size() != 2 || stop_t.size() != 2) begin fails++; $display("FAIL timing got %0d/%0d events exp 2/2", start_t.size(), stop_t.size()); end
    else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (stop_t[k] - start_t[k] + 3 != Q * (2 + 9 * txn_len[k])) begin
          fails++; $display("FAIL span_%0d got %0d exp %0d", k, stop_t[k] - start_t[k] + 3, Q * (2 + 9 * txn_len[k]));
        end
      end
      checks++;
      if (start_t[1] - stop_t[0] - 3 != GAPC) begin fails++; $display("FAIL gap got %0d exp %0d", start_t[1] - stop_t[0] - 3, GAPC); end
    end
  endtask
  task automatic test_completion();
    int e0;
    repeat (3) @(negedge clk);
    checks++;
    if (stop_t.size() != 2 || done_t != stop_t[1] + 2) begin
      fails++; $display("FAIL done_rise got %0d exp %0d", done_t, stop_t.size() == 2 ? stop_t[1] + 2 : -1);
    end
    e0 = edges;
    repeat (10000) @(negedge clk);
    checks++; if (edges != e0) begin fails++; $display("FAIL idle_edges got %0d exp %0d", edges, e0); end
    checks++; if (b.done !== 1'b1 || done_drop != 0) begin fails++; $display("FAIL done_sticky got %b drops %0d exp 1 drops 0", b.done, done_drop); end
    checks++; if (b.scl !== 1'b1 || b.sda_out !== 1'b1) begin fails++; $display("FAIL idle_bus got %b%b exp 11", b.scl, b.sda_out); end
  endtask
  task automatic test_mid_reset();
    int r, tgt, i;
    r = 4 * $urandom_range(0, 8) + ($urandom_range(0, 1) != 0 ? 3 : 0);
    tgt = STARTUP + 1 + Q + 36 * 4 + r;
    rst_n = 1'b0;
    release_reset($urandom_range(1, 8));
    for (i = 0; i < 5000 && cyc - rel_cyc < tgt; i++) @(negedge clk);
    checks++; if (b.scl !== 1'b0) begin fails++; $display("FAIL mid_busy got scl %b exp 0 at %0d", b.scl, cyc - rel_cyc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b.scl !== 1'b1 || b.sda_out !== 1'b1) begin fails++; $display("FAIL mid_reset_bus got %b%b exp 11", b.scl, b.sda_out); end
    checks++; if (b.done !== 1'b0) begin fails++; $display("FAIL mid_reset_done got %b exp 0", b.done); end
    release_reset($urandom_range(1, 8));
    test_startup();
    test_bus_decode();
    test_timing();
  endtask
  initial begin
    foreach (TXN_A[i]) exp_bytes.push_back(TXN_A[i]);
    foreach (TXN_B[i]) exp_bytes.push_back(TXN_B[i]);
    test_reset();
    test_startup();
    test_bus_decode();
    test_timing();
    test_completion();
    test_mid_reset();
    test_completion();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
